// File: rtl/dcache_arb_pkg.sv
// ============================================================================
// dcache_arb_pkg : shared constants and types for the data-cache arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package dcache_arb_pkg;

    localparam int unsigned PortPtw   = 0;
    localparam int unsigned PortLoad  = 1;
    localparam int unsigned PortStore = 2;

    localparam int unsigned DefAddrWidth = 64;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefTagWidth  = 4;

    // Request payload at the default widths; modules with other widths
    // declare the same layout locally from their own parameters.
    typedef struct packed {
        logic [DefAddrWidth-1:0]   addr;
        logic                      we;
        logic [DefDataWidth-1:0]   wdata;
        logic [DefDataWidth/8-1:0] be;
        logic [DefTagWidth-1:0]    tid;
    } dcache_req_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_onehot.sv
// ============================================================================
// rr_arb_onehot : combinational round-robin pick, first eligible from ptr_i up
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arb_onehot #(
    parameter int unsigned N        = 3,
    parameter int unsigned IdxWidth = $clog2(N)
) (
    input  logic [N-1:0]        eligible_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [N-1:0]        gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    logic [IdxWidth-1:0] cand;
    logic                found;

    function automatic int unsigned rot(input logic [IdxWidth-1:0] p, input int unsigned k);
        return (32'(p) + k) % N;
    endfunction

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxWidth'(rot(ptr_i, k));
            if (!found && eligible_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
        any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/dcache_req_arbiter.sv
// ============================================================================
// dcache_req_arbiter : round-robin share of the D$ request port, tagged
// responses demuxed back to requesters, bounded in-flight store count.
// Revision 1.0
// ============================================================================
`default_nettype none

module dcache_req_arbiter
    import dcache_arb_pkg::*;
#(
    parameter  int unsigned NrPorts              = 3,
    parameter  int unsigned StorePort            = PortStore,
    parameter  int unsigned AddrWidth            = 64,
    parameter  int unsigned DataWidth            = 64,
    parameter  int unsigned TidWidth             = 2,
    parameter  int unsigned MaxOutstandingStores = 7,
    parameter  int unsigned PortIdxWidth         = $clog2(NrPorts),
    localparam int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1),
    localparam int unsigned TagWidth             = PortIdxWidth + TidWidth,
    localparam int unsigned BeWidth              = DataWidth / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrPorts-1:0]             req_valid_i,
    output logic [NrPorts-1:0]             req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
    input  logic [NrPorts-1:0]             req_we_i,
    input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
    input  logic [NrPorts*BeWidth-1:0]     req_be_i,
    input  logic [NrPorts*TidWidth-1:0]    req_tid_i,
    output logic                           cache_req_valid_o,
    input  logic                           cache_req_ready_i,
    output logic [AddrWidth-1:0]           cache_req_addr_o,
    output logic                           cache_req_we_o,
    output logic [DataWidth-1:0]           cache_req_wdata_o,
    output logic [BeWidth-1:0]             cache_req_be_o,
    output logic [TagWidth-1:0]            cache_req_tid_o,
    input  logic                           cache_rsp_valid_i,
    input  logic [TagWidth-1:0]            cache_rsp_tid_i,
    input  logic [DataWidth-1:0]           cache_rsp_data_i,
    input  logic                           cache_wack_i,
    output logic [NrPorts-1:0]             rsp_valid_o,
    output logic [TidWidth-1:0]            rsp_tid_o,
    output logic [DataWidth-1:0]           rsp_data_o,
    output logic [CntWidth-1:0]            outstanding_stores_o,
    output logic                           idle_o
);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [DataWidth-1:0] wdata;
        logic [BeWidth-1:0]   be;
        logic [TagWidth-1:0]  tid;
    } req_t;

    req_t                    stage_q, stage_d, winner_req;
    logic                    stage_valid_q, stage_valid_d;
    logic [PortIdxWidth-1:0] rr_q, rr_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;

    logic [NrPorts-1:0]      eligible;
    logic [NrPorts-1:0]      arb_gnt;
    logic [PortIdxWidth-1:0] arb_idx;
    logic                    arb_any;
    logic                    stage_is_store;
    logic                    store_full;
    logic                    stage_free;
    logic                    grant_en;
    logic                    accept;
    logic                    store_acc;
    logic [PortIdxWidth-1:0] rsp_port;

    assign stage_is_store = stage_valid_q &&
                            (stage_q.tid[TagWidth-1 -: PortIdxWidth] == PortIdxWidth'(StorePort));
    // A store waiting in the stage already claims one of the outstanding slots.
    assign store_full = (32'(cnt_q) + 32'(stage_is_store)) >= MaxOutstandingStores;
    assign stage_free = !stage_valid_q || cache_req_ready_i;
    assign grant_en   = stage_free && !rst_i;

    always_comb begin
        eligible = req_valid_i;
        if (store_full) begin
            eligible[StorePort] = 1'b0;
        end
    end

    rr_arb_onehot #(
        .N        (NrPorts),
        .IdxWidth (PortIdxWidth)
    ) u_rr_arb (
        .eligible_i (eligible),
        .ptr_i      (rr_q),
        .gnt_o      (arb_gnt),
        .idx_o      (arb_idx),
        .any_o      (arb_any)
    );

    assign req_ready_o = grant_en ? arb_gnt : '0;
    assign accept      = grant_en && arb_any;

    always_comb begin
        winner_req.addr  = req_addr_i[arb_idx*AddrWidth +: AddrWidth];
        winner_req.we    = req_we_i[arb_idx];
        winner_req.wdata = req_wdata_i[arb_idx*DataWidth +: DataWidth];
        winner_req.be    = req_be_i[arb_idx*BeWidth +: BeWidth];
        winner_req.tid   = {arb_idx, req_tid_i[arb_idx*TidWidth +: TidWidth]};
    end

    always_comb begin
        stage_d       = stage_q;
        stage_valid_d = stage_valid_q;
        rr_d          = rr_q;
        if (accept) begin
            stage_d       = winner_req;
            stage_valid_d = 1'b1;
            rr_d          = PortIdxWidth'(wrap_inc(32'(arb_idx), NrPorts));
        end else if (cache_req_ready_i) begin
            stage_valid_d = 1'b0;
        end
    end

    // Stores count on the cache handshake, not on the requester handshake.
    assign store_acc = stage_is_store && cache_req_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (store_acc && !cache_wack_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!store_acc && cache_wack_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            rr_q          <= '0;
            cnt_q         <= '0;
        end else begin
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cache_req_valid_o    = stage_valid_q;
    assign cache_req_addr_o     = stage_q.addr;
    assign cache_req_we_o       = stage_q.we;
    assign cache_req_wdata_o    = stage_q.wdata;
    assign cache_req_be_o       = stage_q.be;
    assign cache_req_tid_o      = stage_q.tid;
    assign outstanding_stores_o = cnt_q;
    assign idle_o               = !stage_valid_q && (cnt_q == '0);

    assign rsp_port   = cache_rsp_tid_i[TagWidth-1 -: PortIdxWidth];
    assign rsp_tid_o  = cache_rsp_tid_i[TidWidth-1:0];
    assign rsp_data_o = cache_rsp_data_i;

    generate
        for (genvar p = 0; p < NrPorts; p++) begin : g_rsp
            assign rsp_valid_o[p] = cache_rsp_valid_i && (rsp_port == PortIdxWidth'(p));
        end
    endgenerate

`ifndef SYNTHESIS
    a_wack_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        cache_wack_i |-> (cnt_q != '0));
    a_rsp_port_range: assert property (@(posedge clk_i) disable iff (rst_i)
        cache_rsp_valid_i |-> (32'(rsp_port) < NrPorts));
    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));
    a_cnt_bound: assert property (@(posedge clk_i) 32'(cnt_q) <= MaxOutstandingStores);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_req_arbiter.sv
// ============================================================================
// tb_dcache_req_arbiter : directed self-checking bench for dcache_req_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dcache_req_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [2:0]   req_valid_i;
    logic [2:0]   req_ready_o;
    logic [191:0] req_addr_i;
    logic [2:0]   req_we_i;
    logic [191:0] req_wdata_i;
    logic [23:0]  req_be_i;
    logic [5:0]   req_tid_i;
    logic         cache_req_valid_o;
    logic         cache_req_ready_i;
    logic [63:0]  cache_req_addr_o;
    logic         cache_req_we_o;
    logic [63:0]  cache_req_wdata_o;
    logic [7:0]   cache_req_be_o;
    logic [3:0]   cache_req_tid_o;
    logic         cache_rsp_valid_i;
    logic [3:0]   cache_rsp_tid_i;
    logic [63:0]  cache_rsp_data_i;
    logic         cache_wack_i;
    logic [2:0]   rsp_valid_o;
    logic [1:0]   rsp_tid_o;
    logic [63:0]  rsp_data_o;
    logic [2:0]   outstanding_stores_o;
    logic         idle_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dcache_req_arbiter dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_addr_i           (req_addr_i),
        .req_we_i             (req_we_i),
        .req_wdata_i          (req_wdata_i),
        .req_be_i             (req_be_i),
        .req_tid_i            (req_tid_i),
        .cache_req_valid_o    (cache_req_valid_o),
        .cache_req_ready_i    (cache_req_ready_i),
        .cache_req_addr_o     (cache_req_addr_o),
        .cache_req_we_o       (cache_req_we_o),
        .cache_req_wdata_o    (cache_req_wdata_o),
        .cache_req_be_o       (cache_req_be_o),
        .cache_req_tid_o      (cache_req_tid_o),
        .cache_rsp_valid_i    (cache_rsp_valid_i),
        .cache_rsp_tid_i      (cache_rsp_tid_i),
        .cache_rsp_data_i     (cache_rsp_data_i),
        .cache_wack_i         (cache_wack_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_tid_o            (rsp_tid_o),
        .rsp_data_o           (rsp_data_o),
        .outstanding_stores_o (outstanding_stores_o),
        .idle_o               (idle_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic [63:0] a, input logic we, input logic [1:0] t);
        req_addr_i[p*64 +: 64]  = a;
        req_we_i[p]             = we;
        req_wdata_i[p*64 +: 64] = a ^ 64'hFFFF;
        req_be_i[p*8 +: 8]      = 8'hFF;
        req_tid_i[p*2 +: 2]     = t;
    endtask

    initial begin
        rst_i             = 1'b1;
        req_valid_i       = 3'b111;
        req_addr_i        = '0;
        req_we_i          = '0;
        req_wdata_i       = '0;
        req_be_i          = '0;
        req_tid_i         = '0;
        cache_req_ready_i = 1'b1;
        cache_rsp_valid_i = 1'b0;
        cache_rsp_tid_i   = '0;
        cache_rsp_data_i  = '0;
        cache_wack_i      = 1'b0;

        // Reset state
        #1;
        check_eq("rst_ready", 64'(req_ready_o), 64'h0);
        tick;
        check_eq("rst_valid", 64'(cache_req_valid_o), 64'h0);
        check_eq("rst_addr",  cache_req_addr_o, 64'h0);
        check_eq("rst_cnt",   64'(outstanding_stores_o), 64'h0);
        check_eq("rst_idle",  64'(idle_o), 64'h1);
        req_valid_i = 3'b000;
        tick;
        rst_i = 1'b0;

        // Single load on port 1 and its response
        set_port(1, 64'h8000_0040, 1'b0, 2'd1);
        req_valid_i = 3'b010;
        #1;
        check_eq("single_ready", 64'(req_ready_o), 64'h2);
        tick;
        req_valid_i = 3'b000;
        check_eq("single_valid", 64'(cache_req_valid_o), 64'h1);
        check_eq("single_tid",   64'(cache_req_tid_o), 64'h5);
        check_eq("single_addr",  cache_req_addr_o, 64'h8000_0040);
        check_eq("single_we",    64'(cache_req_we_o), 64'h0);
        cache_rsp_valid_i = 1'b1;
        cache_rsp_tid_i   = 4'b0101;
        cache_rsp_data_i  = 64'hDEAD;
        #1;
        check_eq("rsp1_valid", 64'(rsp_valid_o), 64'h2);
        check_eq("rsp1_tid",   64'(rsp_tid_o), 64'h1);
        check_eq("rsp1_data",  rsp_data_o, 64'hDEAD);
        cache_rsp_tid_i  = 4'b1011;
        cache_rsp_data_i = 64'hBEEF;
        #1;
        check_eq("rsp2_valid", 64'(rsp_valid_o), 64'h4);
        check_eq("rsp2_tid",   64'(rsp_tid_o), 64'h3);
        cache_rsp_valid_i = 1'b0;
        #1;
        check_eq("rsp_none", 64'(rsp_valid_o), 64'h0);
        tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;

        // Round-robin with all ports valid
        set_port(0, 64'h1000, 1'b0, 2'd0);
        set_port(1, 64'h2000, 1'b0, 2'd1);
        set_port(2, 64'h3000, 1'b1, 2'd2);
        req_valid_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", i), 64'(req_ready_o), 64'(3'b001 << (i % 3)));
            tick;
        end
        req_valid_i = 3'b000;
        tick;
        check_eq("rr_cnt", 64'(outstanding_stores_o), 64'h2);
        cache_wack_i = 1'b1;
        tick;
        tick;
        cache_wack_i = 1'b0;
        check_eq("rr_cnt_drained", 64'(outstanding_stores_o), 64'h0);
        check_eq("rr_idle", 64'(idle_o), 64'h1);

        // Backpressure holds the stage and blocks grants
        cache_req_ready_i = 1'b0;
        set_port(0, 64'hA000_0000, 1'b0, 2'd2);
        set_port(1, 64'h8000_0040, 1'b0, 2'd1);
        req_valid_i = 3'b001;
        #1;
        check_eq("bp_first_ready", 64'(req_ready_o), 64'h1);
        tick;
        req_valid_i = 3'b010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("bp_ready%0d", i), 64'(req_ready_o), 64'h0);
            check_eq($sformatf("bp_addr%0d", i),  cache_req_addr_o, 64'hA000_0000);
            check_eq($sformatf("bp_tid%0d", i),   64'(cache_req_tid_o), 64'h2);
            check_eq($sformatf("bp_valid%0d", i), 64'(cache_req_valid_o), 64'h1);
            tick;
        end
        cache_req_ready_i = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(req_ready_o), 64'h2);
        tick;
        check_eq("bp_release_tid", 64'(cache_req_tid_o), 64'h5);
        req_valid_i = 3'b000;
        tick;

        // Store limit
        set_port(2, 64'hC000_0000, 1'b1, 2'd3);
        req_valid_i = 3'b100;
        for (int i = 0; i < 7; i++) begin
            #1;
            check_eq($sformatf("st_grant%0d", i), 64'(req_ready_o), 64'h4);
            tick;
        end
        check_eq("st_we", 64'(cache_req_we_o), 64'h1);
        check_eq("st_wdata", cache_req_wdata_o, 64'hC000_0000 ^ 64'hFFFF);
        req_valid_i = 3'b110;
        #1;
        check_eq("st_blocked_a", 64'(req_ready_o), 64'h2);
        tick;
        check_eq("st_cnt_full", 64'(outstanding_stores_o), 64'h7);
        #1;
        check_eq("st_blocked_b", 64'(req_ready_o), 64'h2);
        tick;
        req_valid_i  = 3'b000;
        cache_wack_i = 1'b1;
        tick;
        cache_wack_i = 1'b0;
        check_eq("st_cnt_after_wack", 64'(outstanding_stores_o), 64'h6);
        req_valid_i = 3'b100;
        #1;
        check_eq("st_regrant", 64'(req_ready_o), 64'h4);
        tick;
        req_valid_i = 3'b000;
        tick;
        check_eq("st_cnt_refull", 64'(outstanding_stores_o), 64'h7);
        cache_wack_i = 1'b1;
        repeat (7) tick;
        cache_wack_i = 1'b0;
        check_eq("st_cnt_empty", 64'(outstanding_stores_o), 64'h0);
        check_eq("st_idle", 64'(idle_o), 64'h1);

        // Store accept and write-ack in the same cycle
        req_valid_i = 3'b100;
        repeat (3) begin
            #1;
            check_eq("sim_grant", 64'(req_ready_o), 64'h4);
            tick;
        end
        req_valid_i = 3'b000;
        tick;
        check_eq("sim_cnt3", 64'(outstanding_stores_o), 64'h3);
        cache_req_ready_i = 1'b0;
        req_valid_i = 3'b100;
        #1;
        check_eq("sim_grant4", 64'(req_ready_o), 64'h4);
        tick;
        req_valid_i = 3'b000;
        tick;
        check_eq("sim_cnt_hold", 64'(outstanding_stores_o), 64'h3);
        check_eq("sim_stage_held", 64'(cache_req_valid_o), 64'h1);
        cache_req_ready_i = 1'b1;
        cache_wack_i      = 1'b1;
        tick;
        cache_wack_i = 1'b0;
        check_eq("sim_cnt_same", 64'(outstanding_stores_o), 64'h3);
        check_eq("sim_stage_empty", 64'(cache_req_valid_o), 64'h0);
        check_eq("sim_not_idle", 64'(idle_o), 64'h0);
        cache_wack_i = 1'b1;
        repeat (3) tick;
        cache_wack_i = 1'b0;
        check_eq("sim_cnt0", 64'(outstanding_stores_o), 64'h0);
        check_eq("sim_idle", 64'(idle_o), 64'h1);

        // Reset mid-operation
        req_valid_i = 3'b100;
        repeat (4) tick;
        set_port(0, 64'h1234_0000, 1'b0, 2'd0);
        req_valid_i = 3'b001;
        #1;
        check_eq("mr_grant0", 64'(req_ready_o), 64'h1);
        tick;
        req_valid_i       = 3'b000;
        cache_req_ready_i = 1'b0;
        check_eq("mr_cnt4", 64'(outstanding_stores_o), 64'h4);
        check_eq("mr_valid", 64'(cache_req_valid_o), 64'h1);
        tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        check_eq("mr_valid_cleared", 64'(cache_req_valid_o), 64'h0);
        check_eq("mr_cnt_cleared", 64'(outstanding_stores_o), 64'h0);
        check_eq("mr_idle", 64'(idle_o), 64'h1);
        check_eq("mr_addr_cleared", cache_req_addr_o, 64'h0);
        cache_req_ready_i = 1'b1;
        req_valid_i       = 3'b011;
        #1;
        check_eq("mr_first_grant", 64'(req_ready_o), 64'h1);
        tick;
        req_valid_i = 3'b000;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares the single data-cache request port among NrPorts requesters (default: 0 = PTW, 1 = load unit, 2 = store unit).
- Round-robin arbitration feeds a one-entry registered request stage.
- Tags each request's transaction ID with the source port index, and demultiplexes cache responses back to the owning port by that tag.
- Bounds in-flight stores at MaxOutstandingStores, and reports idle for fence/flush sequencing in the load-store unit.

Parameters:
- NrPorts, 3, number of requesters (>=2)
- StorePort, 2, port index whose requests count as stores
- AddrWidth, 64, request address width
- DataWidth, 64, request/response data width
- TidWidth, 2, per-port transaction ID width (MemTidWidth)
- MaxOutstandingStores, 7, maximum stores accepted but not yet write-acked
- PortIdxWidth, $clog2(NrPorts), derived; port tag width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NrPorts  per-port request valid
- req_ready_o  out  NrPorts  per-port grant/accept
- req_addr_i  in  NrPorts*AddrWidth  per-port address
- req_we_i  in  NrPorts  per-port write enable
- req_wdata_i  in  NrPorts*DataWidth  per-port write data
- req_be_i  in  NrPorts*DataWidth/8  per-port byte enables
- req_tid_i  in  NrPorts*TidWidth  per-port transaction ID
- cache_req_valid_o  out  1  registered request valid
- cache_req_ready_i  in  1  cache accepts request
- cache_req_addr_o  out  AddrWidth  request address
- cache_req_we_o  out  1  request write enable
- cache_req_wdata_o  out  DataWidth  request write data
- cache_req_be_o  out  DataWidth/8  request byte enables
- cache_req_tid_o  out  PortIdxWidth+TidWidth  {port index, requester tid}
- cache_rsp_valid_i  in  1  read response valid
- cache_rsp_tid_i  in  PortIdxWidth+TidWidth  response tag
- cache_rsp_data_i  in  DataWidth  response data
- cache_wack_i  in  1  one store write-acknowledged this cycle
- rsp_valid_o  out  NrPorts  one-hot response valid
- rsp_tid_o  out  TidWidth  requester tid (broadcast)
- rsp_data_o  out  DataWidth  response data (broadcast)
- outstanding_stores_o  out  $clog2(MaxOutstandingStores+1)  in-flight store count
- idle_o  out  1  stage empty AND outstanding stores == 0

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - stage empty; cache_req_valid_o=0; all cache_req_* payload fields 0
  - rr pointer=0; store counter=0; idle_o=1
  - req_ready_o=0 while rst_i is high
  - Reset mid-transfer discards the stage contents without notifying the requester.
- Eligibility:
  - port p is eligible iff req_valid_i[p]
  - StorePort is additionally ineligible when store count + (stage holds a store) >= MaxOutstandingStores
- Stage load condition: stage_free = !cache_req_valid_o || cache_req_ready_i (same-cycle drain-and-refill permitted).
- Grant:
  - when stage_free, the winner is the first eligible port scanning from the rr pointer upward, with wrap-around
  - req_ready_o[winner]=1 combinationally; all other ready bits 0
  - at most one ready bit is set per cycle
- Accept: on a cycle where valid[p] && ready[p]:
  - the stage captures the port-p payload; tid becomes {p, req_tid_i[p]}
  - cache_req_valid_o=1 next cycle (request latency 1 cycle)
  - rr pointer becomes p+1 mod NrPorts
- Hold: while cache_req_valid_o && !cache_req_ready_i, all cache_req_* outputs are held stable and no grant is issued.
- Store counter:
  - +1 when a stage entry with port==StorePort is accepted by the cache (cache handshake, not the requester handshake)
  - -1 on cache_wack_i
  - both in the same cycle: count unchanged
  - cache_wack_i at count 0 is an error: assertion fires, count stays 0
  - the counter never exceeds MaxOutstandingStores
- Response demux:
  - rsp_valid_o[cache_rsp_tid_i upper field] = cache_rsp_valid_i
  - rsp_tid_o / rsp_data_o driven from the lower tid field and data
  - purely combinational, 0 latency
  - an upper field >= NrPorts: no rsp_valid_o asserted, assertion fires
  - responses are independent of the request stage, so a response and a grant may occur in the same cycle
- Fairness: with all ports continuously valid and the cache always ready, grants rotate 0,1,2,0,…

Decomposition:
- Shared package (new dcache_arb_pkg): port index constants (PortPtw, PortLoad, PortStore), and a request struct typedef {addr, we, wdata, be, tid} parameterised by widths.
- One natural sub-module, rr_arb_onehot:
  - eligible vector plus pointer in; one-hot grant and index out
  - combinational, reused for the pointer update

Test Plan:
- Single port: load on port 1, addr 0x8000_0040, tid 1.
  - Response: req_ready_o=3'b010 same cycle; next cycle cache_req_valid_o=1, cache_req_tid_o={2'd1,2'd1}.
  - Cache response with tid {1,1}, data 0xDEAD → rsp_valid_o=3'b010, rsp_tid_o=1, rsp_data_o=0xDEAD.
- Round-robin: all three ports valid, cache always ready, 6 cycles.
  - Response: grant order 0,1,2,0,1,2; exactly one ready bit set per cycle.
- Backpressure: cache_req_ready_i=0 for 4 cycles with the stage holding a port-0 request.
  - Response: payload stable all 4 cycles; req_ready_o=0; on the release cycle the next winner is granted in the same cycle.
- Store limit: 7 stores accepted with no wack.
  - Response: outstanding_stores_o=7; port 2 never granted while port 1 still wins.
  - One cache_wack_i → count 6, port 2 granted next.
- Simultaneous: store accepted by the cache in the same cycle as cache_wack_i, count 3.
  - Response: count stays 3.
  - Separately, when all stores are acked and the stage is empty → idle_o=1.
- Reset mid-operation: rst_i asserted while the stage is valid with count 4.
  - Response: next cycle cache_req_valid_o=0, count 0, idle_o=1, rr pointer 0 (the first grant after reset goes to the lowest valid port).
